// File: rtl/houghlines_accel_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit for the Hough accelerator.
// Latency is 3 + MUL_STAGES edges from operand capture to dout.
module houghlines_accel_mac_pipe #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 24,
  parameter int SIGNED     = 0,
  parameter int MUL_STAGES = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic                  acc_en,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);

  localparam int PW  = din0_WIDTH + din1_WIDTH;
  localparam int MSB = dout_WIDTH - 1;

  typedef struct packed {
    logic vld;
    logic acc;
    logic first;
    logic last;
  } ctl_t;

  logic [din0_WIDTH-1:0] a_q;
  logic [din1_WIDTH-1:0] b_q;
  ctl_t                  s1_ctl;

  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [dout_WIDTH-1:0] prod_ext;

  logic [dout_WIDTH-1:0] p_q   [MUL_STAGES];
  ctl_t                  p_ctl [MUL_STAGES];

  logic [dout_WIDTH-1:0] p_t;
  ctl_t                  c_t;

  logic [dout_WIDTH-1:0] acc_q, res_q;
  logic                  ovf_acc, res_vld;

  logic [dout_WIDTH:0]   sum_wide;
  logic [dout_WIDTH-1:0] sum, acc_nxt;
  logic                  add_ovf, ovf_nxt;

  // A PW-bit truncated multiply of PW-bit extended operands is exact for both
  // signed and unsigned operands, since the true product always fits in PW bits.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext    = PW'($signed(a_q));
      b_ext    = PW'($signed(b_q));
    end else begin
      a_ext    = PW'(a_q);
      b_ext    = PW'(b_q);
    end
    prod = a_ext * b_ext;
    if (SIGNED != 0) prod_ext = dout_WIDTH'($signed(prod));
    else             prod_ext = dout_WIDTH'(prod);
  end

  assign p_t = p_q[MUL_STAGES-1];
  assign c_t = p_ctl[MUL_STAGES-1];

  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, p_t};
    sum      = sum_wide[MSB:0];
    if (SIGNED != 0) add_ovf = (acc_q[MSB] == p_t[MSB]) && (sum[MSB] != acc_q[MSB]);
    else             add_ovf = sum_wide[dout_WIDTH];
    acc_nxt = sum;
    if (add_ovf && (SATURATE != 0)) begin
      // Signed overflow direction follows the (shared) operand sign.
      if (SIGNED != 0) acc_nxt = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      else             acc_nxt = '1;
    end
    if (c_t.first) acc_nxt = p_t;
    ovf_nxt = c_t.first ? 1'b0 : (ovf_acc | add_ovf);
  end

  // NOTE: datapath registers carry no reset; the valid bits alongside them
  // guarantee stale data is never consumed, so only control state is reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q      <= din0;
      b_q      <= din1;
      p_q[0]   <= prod_ext;
      for (int i = 1; i < MUL_STAGES; i++) p_q[i] <= p_q[i-1];
      if (c_t.vld) res_q <= c_t.acc ? acc_nxt : p_t;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_ctl   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) p_ctl[i] <= '0;
      acc_q    <= '0;
      ovf_acc  <= 1'b0;
      res_vld  <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      s1_ctl   <= {in_vld, acc_en, in_first, in_last};
      p_ctl[0] <= s1_ctl;
      for (int i = 1; i < MUL_STAGES; i++) p_ctl[i] <= p_ctl[i-1];

      res_vld <= 1'b0;
      if (c_t.vld) begin
        if (c_t.acc) begin
          acc_q   <= acc_nxt;
          ovf_acc <= ovf_nxt;
          res_vld <= c_t.last;
        end else begin
          res_vld <= 1'b1;
        end
      end

      dout_vld <= res_vld;
      if (res_vld) dout <= res_q;
      ovf <= ovf_acc;
    end
  end

endmodule
